// File: rtl/ahb_resp_mux_n_if.sv
// ahb_resp_mux_n_if: shared bus types and the slave-to-master response bus
// Definitions: DATAWIDTH and Response_t (OKAY=0, ERROR=1).
// Signals: HSEL/HTRANS address phase, per-slave HRDATA_in/HRESP_in/HREADYOUT_in,
// muxed HRDATA_out/HRESP_out/HREADY_out, and the default-slave err_count.
package Definitions;
  localparam int DATAWIDTH = 32;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} Response_t;
endpackage

interface ahb_resp_mux_n_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATAWIDTH = Definitions::DATAWIDTH,
  parameter int ERRCNT_W = 8
);
  import Definitions::*;
  logic [NUM_SLAVES-1:0] HSEL;
  logic [1:0] HTRANS;
  logic [NUM_SLAVES*DATAWIDTH-1:0] HRDATA_in;
  Response_t HRESP_in [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] HREADYOUT_in;
  logic [DATAWIDTH-1:0] HRDATA_out;
  Response_t HRESP_out;
  logic HREADY_out;
  logic [ERRCNT_W-1:0] err_count;
  modport slave (input HSEL, HTRANS, HRDATA_in, HRESP_in, HREADYOUT_in,
                 output HRDATA_out, HRESP_out, HREADY_out, err_count);
  modport master (output HSEL, HTRANS, HRDATA_in, HRESP_in, HREADYOUT_in,
                  input HRDATA_out, HRESP_out, HREADY_out, err_count);
endinterface

// File: rtl/ahb_resp_mux_n.sv
// ahb_resp_mux_n: AHB-Lite response mux with registered data-phase select and built-in ERROR default slave
// Ports: HCLK, HRESET (sync active-high), bus (ahb_resp_mux_n_if.slave).
module ahb_resp_mux_n
  import Definitions::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATAWIDTH = Definitions::DATAWIDTH,
  parameter int ERRCNT_W = 8
) (
  input logic HCLK,
  input logic HRESET,
  ahb_resp_mux_n_if.slave bus
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;
  dstate_t state;
  logic [SW-1:0] sel_q, sel_d;
  logic def_q, def_d, act_q, start_err;
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (bus.HSEL[i]) sel_d = SW'(i);
  end
  // zero or multi-hot selects fall through to the default slave
  assign def_d = (bus.HSEL == '0) || ((bus.HSEL & (bus.HSEL - NUM_SLAVES'(1))) != '0);
  assign start_err = bus.HREADY_out && def_d && bus.HTRANS[1];
  assign bus.HRDATA_out = def_q ? '0 : bus.HRDATA_in[sel_q*DATAWIDTH +: DATAWIDTH];
  assign bus.HRESP_out = def_q ? ((state == D_IDLE) ? OKAY : ERROR) : bus.HRESP_in[sel_q];
  assign bus.HREADY_out = def_q ? (state != D_ERR1) : bus.HREADYOUT_in[sel_q];
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= '0;
      def_q <= 1'b1;
      act_q <= 1'b0;
      state <= D_IDLE;
      bus.err_count <= '0;
    end else begin
      if (bus.HREADY_out) begin
        sel_q <= sel_d;
        def_q <= def_d;
        act_q <= bus.HTRANS[1];
      end
      // ERR1 always advances; ERR2 and IDLE are sample edges that may start a new error
      state <= start_err ? D_ERR1 : (state == D_ERR1) ? D_ERR2 : D_IDLE;
      if (state == D_ERR1 && act_q && !(&bus.err_count))
        bus.err_count <= bus.err_count + ERRCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// tb_ahb_resp_mux_n: scoreboard bench for ahb_resp_mux_n
module tb_ahb_resp_mux_n;
  import Definitions::*;
  typedef struct {
    logic [31:0] rd;
    logic resp;
    logic rdy;
    logic [7:0] cnt;
  } exp_t;
  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'h2222_2222, D2 = 32'hA5A5_A5A5, D3 = 32'h3333_3333;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  ahb_resp_mux_n_if #(.NUM_SLAVES(4), .DATAWIDTH(32), .ERRCNT_W(8)) bus ();
  ahb_resp_mux_n #(.NUM_SLAVES(4), .DATAWIDTH(32), .ERRCNT_W(8)) dut (
    .HCLK(clk),
    .HRESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] s, input logic [1:0] t,
                       input logic [3:0] rdy, input logic [3:0] resp);
    rst = r;
    bus.HSEL = s;
    bus.HTRANS = t;
    bus.HREADYOUT_in = rdy;
    for (int k = 0; k < 4; k++) bus.HRESP_in[k] = resp[k] ? ERROR : OKAY;
  endtask
  task automatic step(input logic r, input logic [3:0] s, input logic [1:0] t,
                      input logic [3:0] rdy, input logic [3:0] resp,
                      input logic [31:0] erd, input logic eresp, input logic erdy, input logic [7:0] ecnt);
    drive(r, s, t, rdy, resp);
    sb.push_back('{erd, eresp, erdy, ecnt});
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      automatic exp_t e = sb.pop_front();
      check("hrdata", 64'(bus.HRDATA_out), 64'(e.rd));
      check("hresp", 64'(bus.HRESP_out), 64'(e.resp));
      check("hready", 64'(bus.HREADY_out), 64'(e.rdy));
      check("err_count", 64'(bus.err_count), 64'(e.cnt));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction
  initial begin
    bus.HRDATA_in = {D3, D2, D1, D0};
    @(posedge clk); #1;
    drive(1'b1, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    @(posedge clk); #1;
    step(1'b1, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 0, 0, 1, 0);
    // routed transfer to slave 2 with two wait states; HSEL change mid-wait is ignored
    step(0, 4'b0100, NS, 4'hF, 0, 0, 0, 1, 0);
    step(0, 4'b0001, NS, 4'b1011, 0, D2, 0, 0, 0);
    step(0, 4'b0001, NS, 4'b1011, 0, D2, 0, 0, 0);
    step(0, 4'b0001, NS, 4'hF, 0, D2, 0, 1, 0);
    // pipelined slave 0 then slave 3, then an unmapped NONSEQ
    step(0, 4'b1000, SQ, 4'hF, 0, D0, 0, 1, 0);
    step(0, 4'b0000, NS, 4'hF, 0, D3, 0, 1, 0);
    step(0, 4'b0000, IDLE, 4'hF, 0, 0, 1, 0, 0);
    step(0, 4'b0110, NS, 4'hF, 0, 0, 1, 1, 1);
    step(0, 4'b0000, IDLE, 4'hF, 0, 0, 1, 0, 1);
    step(0, 4'b0000, IDLE, 4'hF, 0, 0, 1, 1, 2);
    // unmapped IDLE gets zero-wait OKAY; slave 1 returns its own ERROR
    step(0, 4'b0010, NS, 4'hF, 0, 0, 0, 1, 2);
    step(0, 4'b0000, IDLE, 4'hF, 4'b0010, D1, 1, 1, 2);
    // 257 back-to-back unmapped transfers saturate the counter
    step(0, 4'b0000, NS, 4'hF, 0, 0, 0, 1, 2);
    for (int i = 0; i < 257; i++) begin
      step(0, 4'b0000, IDLE, 4'hF, 0, 0, 1, 0, sat(2 + i));
      step(0, 4'b0000, (i < 256) ? NS : IDLE, 4'hF, 0, 0, 1, 1, sat(3 + i));
    end
    // reset during ERR1 abandons the error
    step(0, 4'b0000, NS, 4'hF, 0, 0, 0, 1, 255);
    step(1, 4'b0000, NS, 4'hF, 0, 0, 1, 0, 255);
    step(0, 4'b0000, IDLE, 4'hF, 0, 0, 0, 1, 0);
    step(0, 4'b0100, IDLE, 4'hF, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
